rijndael_shiftrows_pipe: RTL and testbench

Parametrised, pipelined ShiftRows/InvShiftRows engine for the RISC-V crypto extension datapath. It supports the full Rijndael block widths (Nb = 4, 6, 8 columns), per-transaction forward, inverse or bypass mode, and a valid/ready handshake with configurable register depth. It sits between the SubBytes and MixColumns stages of the round pipeline and carries a sideband tag so the round controller can match results to requests.

---
 rtl/rijndael_pkg.sv | 24 ++
 rtl/rijndael_shiftrows_perm.sv | 35 +++
 rtl/rijndael_shiftrows_pipe.sv | 123 ++++++++++++
 tb/tb_rijndael_shiftrows_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rijndael_pkg.sv
// Shared types and index helpers for the Rijndael ShiftRows datapath.
// Byte (r,c) of a column-major state sits at bits [byte_idx(r,c,nb) -: 8].
package rijndael_pkg;

    typedef enum logic [1:0] {
        SR_FWD = 2'b00,
        SR_INV = 2'b01,
        SR_BYP = 2'b10
    } sr_mode_e;

    // Row rotation amount; the 256-bit block widens the gap for rows 2 and 3.
    function automatic int shift_off(input int nb, input int r);
        if ((nb == 32'sd8) && (r >= 32'sd2)) begin
            shift_off = r + 32'sd1;
        end else begin
            shift_off = r;
        end
    endfunction

    function automatic int byte_idx(input int r, input int c, input int nb);
        byte_idx = (32'sd32 * nb) - 32'sd1 - (32'sd8 * ((32'sd4 * c) + r));
    endfunction

endpackage

// File: rtl/rijndael_shiftrows_perm.sv
// Pure combinational ShiftRows / InvShiftRows / bypass permutation.
// Both directions are plain wiring; the mode only steers the output mux.
module rijndael_shiftrows_perm #(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state_i,
    input  logic [1:0]       mode_i,
    output logic [32*NB-1:0] state_o
);
    import rijndael_pkg::*;

    logic [32*NB-1:0] fwd_s;
    logic [32*NB-1:0] inv_s;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST = byte_idx(r, c, NB);
            localparam int FSRC = byte_idx(r, (c + shift_off(NB, r)) % NB, NB);
            localparam int ISRC = byte_idx(r, (c - shift_off(NB, r) + NB) % NB, NB);
            assign fwd_s[DST -: 8] = state_i[FSRC -: 8];
            assign inv_s[DST -: 8] = state_i[ISRC -: 8];
        end
    end

    // Mode select; the unused encoding 11 falls through to bypass.
    always_comb begin
        state_o = state_i;
        case (mode_i)
            SR_FWD:  state_o = fwd_s;
            SR_INV:  state_o = inv_s;
            default: state_o = state_i;
        endcase
    end

endmodule

// File: rtl/rijndael_shiftrows_pipe.sv
// Pipelined ShiftRows engine: permutation at the input, then STAGES
// valid/ready registers carrying state and tag, plus an occupancy counter.
module rijndael_shiftrows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [32*NB-1:0]             in_state_i,
    input  logic [1:0]                   in_mode_i,
    input  logic [TAG_W-1:0]             in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [32*NB-1:0]             out_state_o,
    output logic [TAG_W-1:0]             out_tag_o,
    output logic [$clog2(STAGES+1)-1:0]  count_o
);
    import rijndael_pkg::*;

    localparam int W  = 32 * NB;
    localparam int CW = $clog2(STAGES + 1);

    if (!((NB == 32'sd4) || (NB == 32'sd6) || (NB == 32'sd8))) begin : g_bad_nb
        $error("rijndael_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if ((STAGES < 32'sd1) || (STAGES > 32'sd4)) begin : g_bad_stages
        $error("rijndael_shiftrows_pipe: STAGES must be in 1..4");
    end

    logic [W-1:0]      perm_s;
    logic [STAGES:0]   ready_s;
    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] v_next_s;
    logic [W-1:0]      data_s [STAGES];
    logic [TAG_W-1:0]  tag_s  [STAGES];
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;

    rijndael_shiftrows_perm #(.NB(NB)) u_perm (
        .state_i (in_state_i),
        .mode_i  (in_mode_i),
        .state_o (perm_s)
    );

    // Ready ripples back from the sink: a stage can take new data if it is empty or draining.
    always_comb begin
        ready_s = '0;
        ready_s[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_s[k] = ~v_s[k] | ready_s[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_r;
        logic [W-1:0]     data_r;
        logic [TAG_W-1:0] tag_r;
        logic             up_v_s;
        logic [W-1:0]     up_data_s;
        logic [TAG_W-1:0] up_tag_s;

        if (k == 0) begin : g_head
            assign up_v_s    = in_valid_i;
            assign up_data_s = perm_s;
            assign up_tag_s  = in_tag_i;
        end else begin : g_body
            assign up_v_s    = v_s[k-1];
            assign up_data_s = data_s[k-1];
            assign up_tag_s  = tag_s[k-1];
        end

        assign v_next_s[k] = ready_s[k] ? up_v_s : v_r;

        // Stage register: payload only moves on a real handshake so an empty stage keeps its last data.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_r    <= 1'b0;
                data_r <= '0;
                tag_r  <= '0;
            end else begin
                v_r <= v_next_s[k];
                if (ready_s[k] && up_v_s) begin
                    data_r <= up_data_s;
                    tag_r  <= up_tag_s;
                end else begin
                    data_r <= data_r;
                    tag_r  <= tag_r;
                end
            end
        end

        assign v_s[k]    = v_r;
        assign data_s[k] = data_r;
        assign tag_s[k]  = tag_r;
    end

    // Occupancy is the population of next-state valids, so it lands on the same edge as them.
    always_comb begin
        count_next_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            count_next_s = count_next_s + CW'(v_next_s[k]);
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign in_ready_o  = ready_s[0];
    assign out_valid_o = v_s[STAGES-1];
    assign out_state_o = data_s[STAGES-1];
    assign out_tag_o   = tag_s[STAGES-1];
    assign count_o     = count_r;

endmodule

// File: tb/tb_rijndael_shiftrows_pipe.sv
// Scoreboard bench for rijndael_shiftrows_pipe: a 128-bit/3-stage instance
// and a 256-bit/1-stage instance checked against a byte-array reference.
module tb_rijndael_shiftrows_pipe;

    localparam int SA = 3;
    localparam int SB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [127:0] a_in_state = '0, a_out_state;
    logic [1:0]   a_in_mode = 2'b00;
    logic [3:0]   a_in_tag = 4'h0, a_out_tag;
    logic [1:0]   a_count;

    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [255:0] b_in_state = '0, b_out_state;
    logic [1:0]   b_in_mode = 2'b00;
    logic [3:0]   b_in_tag = 4'h0, b_out_tag;
    logic [0:0]   b_count;

    logic [255:0] a_sq[$];
    logic [3:0]   a_tq[$];
    logic [255:0] b_sq[$];
    logic [3:0]   b_tq[$];

    logic         a_hold = 1'b0, b_hold = 1'b0;
    logic [127:0] a_prev_state;
    logic [255:0] b_prev_state;
    logic [3:0]   a_prev_tag, b_prev_tag;

    rijndael_shiftrows_pipe #(.NB(4), .STAGES(SA), .TAG_W(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_state_i(a_in_state),
        .in_mode_i(a_in_mode), .in_tag_i(a_in_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_state_o(a_out_state),
        .out_tag_o(a_out_tag), .count_o(a_count)
    );

    rijndael_shiftrows_pipe #(.NB(8), .STAGES(SB), .TAG_W(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_state_i(b_in_state),
        .in_mode_i(b_in_mode), .in_tag_i(b_in_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_state_o(b_out_state),
        .out_tag_o(b_out_tag), .count_o(b_count)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: unpack to bytes indexed 4c+r, rotate each row, repack.
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] s, input logic [1:0] mode);
        logic [7:0]   ib [32];
        logic [7:0]   ob [32];
        logic [255:0] res;
        int sh, src;
        res = '0;
        for (int i = 0; i < 4 * nb; i++) ib[i] = s[32*nb-1-8*i -: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh = (nb == 8 && r >= 2) ? r + 1 : r;
                if (mode == 2'b00)      src = (c + sh) % nb;
                else if (mode == 2'b01) src = (c - sh + nb) % nb;
                else                    src = c;
                ob[4*c+r] = ib[4*src+r];
            end
        end
        for (int i = 0; i < 4 * nb; i++) res[32*nb-1-8*i -: 8] = ob[i];
        return res;
    endfunction

    // Monitor A: occupancy/ready model, stall stability, in-order pops, pushes on accept.
    always @(negedge clk) begin
        if (rst) begin
            a_sq.delete(); a_tq.delete(); a_hold = 1'b0;
        end else begin
            chk("a_count", 256'(a_count), 256'(a_sq.size()));
            chk("a_in_ready", 256'(a_in_ready), 256'((a_sq.size() < SA) || a_out_ready));
            if (a_hold) begin
                chk("a_hold_valid", 256'(a_out_valid), 256'(1));
                chk("a_hold_state", 256'(a_out_state), 256'(a_prev_state));
                chk("a_hold_tag", 256'(a_out_tag), 256'(a_prev_tag));
            end
            if (a_out_valid && a_out_ready) begin
                if (a_sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_spurious: got output tag %0h expected no output", a_out_tag);
                end else begin
                    chk("a_state", 256'(a_out_state), a_sq.pop_front());
                    chk("a_tag", 256'(a_out_tag), 256'(a_tq.pop_front()));
                end
            end
            a_hold = a_out_valid && !a_out_ready;
            a_prev_state = a_out_state;
            a_prev_tag = a_out_tag;
            if (a_in_valid && a_in_ready) begin
                a_sq.push_back(ref_perm(4, 256'(a_in_state), a_in_mode));
                a_tq.push_back(a_in_tag);
            end
        end
    end

    // Monitor B: same scheme for the 256-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            b_sq.delete(); b_tq.delete(); b_hold = 1'b0;
        end else begin
            chk("b_count", 256'(b_count), 256'(b_sq.size()));
            chk("b_in_ready", 256'(b_in_ready), 256'((b_sq.size() < SB) || b_out_ready));
            if (b_hold) begin
                chk("b_hold_valid", 256'(b_out_valid), 256'(1));
                chk("b_hold_state", b_out_state, b_prev_state);
                chk("b_hold_tag", 256'(b_out_tag), 256'(b_prev_tag));
            end
            if (b_out_valid && b_out_ready) begin
                if (b_sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_spurious: got output tag %0h expected no output", b_out_tag);
                end else begin
                    chk("b_state", b_out_state, b_sq.pop_front());
                    chk("b_tag", 256'(b_out_tag), 256'(b_tq.pop_front()));
                end
            end
            b_hold = b_out_valid && !b_out_ready;
            b_prev_state = b_out_state;
            b_prev_tag = b_out_tag;
            if (b_in_valid && b_in_ready) begin
                b_sq.push_back(ref_perm(8, b_in_state, b_in_mode));
                b_tq.push_back(b_in_tag);
            end
        end
    end

    task automatic kat_a(input string nm, input logic [127:0] st, input logic [1:0] md,
                         input logic [3:0] tg, input logic [127:0] exp);
        int lat;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_state = st; a_in_mode = md; a_in_tag = tg; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 256'(lat), 256'(SA));
        chk({nm, "_state"}, 256'(a_out_state), 256'(exp));
        chk({nm, "_tag"}, 256'(a_out_tag), 256'(tg));
    endtask

    task automatic kat_b(input string nm, input logic [255:0] st, input logic [1:0] md,
                         input logic [3:0] tg, output logic [255:0] got);
        int lat;
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_state = st; b_in_mode = md; b_in_tag = tg; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 256'(lat), 256'(SB));
        chk({nm, "_tag"}, 256'(b_out_tag), 256'(tg));
        got = b_out_state;
    endtask

    task automatic drain();
        int n;
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        n = 0;
        while ((a_sq.size() != 0 || b_sq.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_drained", 256'(a_sq.size()), 256'(0));
        chk("b_drained", 256'(b_sq.size()), 256'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] seq, fwd_b, inv_b;
        logic acc;
        int idx;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 256'(a_out_valid), 256'(0));
        chk("rst_a_state", 256'(a_out_state), 256'(0));
        chk("rst_a_tag", 256'(a_out_tag), 256'(0));
        chk("rst_a_count", 256'(a_count), 256'(0));
        chk("rst_a_ready", 256'(a_in_ready), 256'(1));
        chk("rst_b_valid", 256'(b_out_valid), 256'(0));
        chk("rst_b_state", b_out_state, 256'(0));

        // Known-answer vectors on the 128-bit instance.
        kat_a("kat_fwd", 128'hd42711aee0bf98f1b8b45de51e415230, 2'b00, 4'h5,
              128'hd4bf5d30e0b452aeb84111f11e2798e5);
        kat_a("kat_inv", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 2'b01, 4'h6,
              128'hd42711aee0bf98f1b8b45de51e415230);
        kat_a("kat_byp", 128'h0123456789abcdeffedcba9876543210, 2'b10, 4'h7,
              128'h0123456789abcdeffedcba9876543210);
        kat_a("kat_m11", 128'hcafef00d5566778899aabbccddeeff00, 2'b11, 4'h8,
              128'hcafef00d5566778899aabbccddeeff00);

        // 256-bit block: bytes 00..1f, forward then inverse of the result.
        for (int i = 0; i < 32; i++) seq[255-8*i -: 8] = 8'(i);
        kat_b("kat8_fwd", seq, 2'b00, 4'h3, fwd_b);
        chk("kat8_fwd_col0", 256'(fwd_b[255:224]), 256'(32'h00050e13));
        kat_b("kat8_inv", fwd_b, 2'b01, 4'h4, inv_b);
        chk("kat8_inv_restore", inv_b, seq);

        // Back-to-back stream of 10 into a stalled 3-stage pipe, then release.
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        idx = 0;
        a_in_valid = 1'b1; a_in_state = {4{$urandom}}; a_in_mode = 2'($urandom_range(0, 3)); a_in_tag = 4'(idx);
        for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (cyc == 5) begin
                chk("full_count", 256'(a_count), 256'(SA));
                chk("full_in_ready", 256'(a_in_ready), 256'(0));
                chk("full_out_valid", 256'(a_out_valid), 256'(1));
            end
            @(posedge clk); #1;
            if (cyc == 5) a_out_ready = 1'b1;
            if (acc) begin
                idx++;
                if (idx < 10) begin
                    a_in_state = {4{$urandom}}; a_in_mode = 2'($urandom_range(0, 3)); a_in_tag = 4'(idx);
                end else begin
                    a_in_valid = 1'b0;
                end
            end
        end
        chk("stream_sent", 256'(idx), 256'(10));
        drain();

        // Random valid/ready on both sides with mixed modes.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'($urandom_range(0, 1)); a_in_state = {4{$urandom}};
            a_in_mode = 2'($urandom_range(0, 3)); a_in_tag = 4'($urandom); a_out_ready = 1'($urandom_range(0, 1));
            b_in_valid = 1'($urandom_range(0, 1)); b_in_state = {8{$urandom}};
            b_in_mode = 2'($urandom_range(0, 3)); b_in_tag = 4'($urandom); b_out_ready = 1'($urandom_range(0, 1));
        end
        drain();

        // Mid-flight reset with two stages occupied.
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_state = {4{$urandom}}; a_in_tag = 4'h1;
        @(posedge clk); #1;
        a_in_state = {4{$urandom}}; a_in_tag = 4'h2;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", 256'(a_count), 256'(2));
        @(posedge clk); #1;
        rst = 1'b1; a_in_valid = 1'b1; a_in_tag = 4'h3;
        @(posedge clk); #1;
        rst = 1'b0; a_in_valid = 1'b0;
        chk("post_rst_valid", 256'(a_out_valid), 256'(0));
        chk("post_rst_count", 256'(a_count), 256'(0));
        chk("post_rst_ready", 256'(a_in_ready), 256'(1));
        chk("post_rst_state", 256'(a_out_state), 256'(0));
        chk("post_rst_tag", 256'(a_out_tag), 256'(0));
        kat_a("post_rst_kat", 128'hd42711aee0bf98f1b8b45de51e415230, 2'b00, 4'h9,
              128'hd4bf5d30e0b452aeb84111f11e2798e5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
